// File: rtl/usb_task_sched.sv
// Round-robin front-end for the read/write datapath: grants one requester at a
// time, issues its task, retries failed/timed-out attempts, and returns status.

module usb_task_sched_port #(
  parameter int IW  = 1,
  parameter int IDX = 0
) (
  input  logic          i_grant_en,
  input  logic [IW-1:0] i_grant_sel,
  input  logic          i_resp_en,
  input  logic [IW-1:0] i_resp_sel,
  output logic          o_ready,
  output logic          o_resp
);
  assign o_ready = i_grant_en && (i_grant_sel == IW'(IDX));
  assign o_resp  = i_resp_en  && (i_resp_sel  == IW'(IDX));
endmodule

module usb_task_sched #(
  parameter int NREQ      = 2,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0][1:0]  req_tsk,
  input  logic [NREQ-1:0][15:0] req_mempage,
  input  logic [NREQ-1:0][63:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  output logic                  resp_success,
  output logic [63:0]           resp_data,
  output logic [1:0]            tsk,
  output logic [15:0]           mempage,
  output logic [63:0]           data_in,
  output logic                  task_clr,
  input  logic                  task_done,
  input  logic                  task_success,
  input  logic [63:0]           read_data,
  output logic                  busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CLEAR, S_RESP} state_t;
  typedef struct packed {
    logic [1:0]  tsk;
    logic [15:0] page;
    logic [63:0] data;
  } task_t;

  state_t        r_state, w_next;
  task_t         r_task;
  logic [IW-1:0] r_g, r_last;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_timer;
  logic          r_pend, r_ok, r_resp_ok;
  logic [63:0]   r_rdata, r_resp_data;

  logic          w_found, w_legal, w_tmo, w_drive;
  logic [IW-1:0] w_gidx;

  // Walk from farthest to nearest so the slot right after last_grant wins.
  always_comb begin
    logic [IW-1:0] w_sel;
    w_found = 1'b0;
    w_gidx  = '0;
    w_sel   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_sel = IW'((int'(r_last) + k) % NREQ);
      if (req_valid[w_sel]) begin
        w_found = 1'b1;
        w_gidx  = w_sel;
      end
    end
  end

  assign w_legal = (req_tsk[w_gidx] == 2'b01) || (req_tsk[w_gidx] == 2'b10);
  assign w_tmo   = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found) w_next = w_legal ? S_ISSUE : S_RESP;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (task_done || w_tmo) w_next = S_CLEAR;
      S_CLEAR: w_next = r_pend ? S_ISSUE : S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_task      <= '0;
      r_g         <= '0;
      r_last      <= IW'(NREQ - 1);
      r_retry     <= '0;
      r_timer     <= '0;
      r_pend      <= 1'b0;
      r_ok        <= 1'b0;
      r_rdata     <= '0;
      r_resp_ok   <= 1'b0;
      r_resp_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_found) begin
          r_task  <= '{tsk: req_tsk[w_gidx], page: req_mempage[w_gidx], data: req_data[w_gidx]};
          r_g     <= w_gidx;
          r_retry <= '0;
          r_ok    <= 1'b0;
          r_rdata <= '0;
          // Illegal codes skip the datapath and report failure directly.
          if (!w_legal) begin
            r_resp_ok   <= 1'b0;
            r_resp_data <= '0;
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (task_done && task_success) begin
            r_ok    <= 1'b1;
            r_rdata <= (r_task.tsk == 2'b01) ? read_data : '0;
          end else if (task_done || w_tmo) begin
            if (r_retry < RW'(MAX_RETRY)) begin
              r_retry <= r_retry + 1'b1;
              r_pend  <= 1'b1;
            end else begin
              r_ok    <= 1'b0;
              r_rdata <= '0;
            end
          end
        end
        S_CLEAR: begin
          r_pend <= 1'b0;
          if (!r_pend) begin
            r_resp_ok   <= r_ok;
            r_resp_data <= r_rdata;
          end
        end
        S_RESP: begin
          r_last  <= r_g;
          r_retry <= '0;
        end
        default: ;
      endcase
    end
  end

  assign w_drive      = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign tsk          = w_drive ? r_task.tsk  : '0;
  assign mempage      = w_drive ? r_task.page : '0;
  assign data_in      = w_drive ? r_task.data : '0;
  assign task_clr     = (r_state == S_CLEAR);
  assign busy         = (r_state != S_IDLE);
  assign resp_success = r_resp_ok;
  assign resp_data    = r_resp_data;

  // Grant is combinational in IDLE; held off while reset is asserted.
  for (genvar i = 0; i < NREQ; i++) begin : g_port
    usb_task_sched_port #(.IW(IW), .IDX(i)) u_port (
      .i_grant_en  (rst_b && (r_state == S_IDLE) && w_found),
      .i_grant_sel (w_gidx),
      .i_resp_en   (r_state == S_RESP),
      .i_resp_sel  (r_g),
      .o_ready     (req_ready[i]),
      .o_resp      (resp_valid[i])
    );
  end
endmodule

// File: tb/tb_usb_task_sched.sv
// Scoreboard bench: stimulus pushes expected grants/attempts/responses,
// independent monitors pop and compare as the DUT presents them.

module tb_usb_task_sched;
  localparam int NREQ = 2, MAXR = 2, TMO = 16;

  logic clk = 1'b0, rst_b = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][1:0]  req_tsk;
  logic [NREQ-1:0][15:0] req_mempage;
  logic [NREQ-1:0][63:0] req_data;
  logic [NREQ-1:0]       req_ready, resp_valid;
  logic                  resp_success, task_clr, busy;
  logic [63:0]           resp_data, data_in, read_data;
  logic [1:0]            tsk;
  logic [15:0]           mempage;
  logic                  task_done, task_success;

  usb_task_sched #(.NREQ(NREQ), .MAX_RETRY(MAXR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_tsk(req_tsk),
    .req_mempage(req_mempage), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_success(resp_success), .resp_data(resp_data),
    .tsk(tsk), .mempage(mempage), .data_in(data_in), .task_clr(task_clr),
    .task_done(task_done), .task_success(task_success), .read_data(read_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; logic ok; logic [63:0] data; int lat;} resp_t;
  typedef struct {int delay; logic ok; logic [63:0] rdata; logic [1:0] tsk;
                  logic [15:0] page; logic [63:0] wdata;} att_t;

  resp_t sb[$];
  att_t  atq[$];
  int    gq[$];
  int    gtime[NREQ];
  int    cyc = 0, n_vec = 0, n_err = 0, clr_cnt = 0, iss_cnt = 0;
  bit    m_active;
  int    m_cnt;
  att_t  m_cur;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({req_ready, resp_valid, resp_success, tsk, task_clr, busy}), 64'd0);
    chk({tag, "_data"}, resp_data | data_in, 64'd0);
    chk({tag, "_page"}, 64'(mempage), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Grant monitor and task_clr counter.
  initial forever begin
    @(negedge clk);
    if (rst_b) begin
      if (task_clr) clr_cnt++;
      if (req_ready != 0) chk("grant_onehot", 64'($countones(req_ready)), 64'd1);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin
        gtime[i] = cyc;
        if (gq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL grant_unexpected: req_ready=%b with none expected", req_ready);
        end else chk("grant_idx", 64'(i), 64'(gq.pop_front()));
      end
    end
  end

  // Response scoreboard.
  initial forever begin
    resp_t e;
    @(negedge clk);
    if (rst_b && resp_valid != 0) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL resp_unexpected: resp_valid=%b with none expected", resp_valid);
      end else begin
        e = sb.pop_front();
        chk("resp_valid",   64'(resp_valid), 64'(1 << e.idx));
        chk("resp_success", 64'(resp_success), 64'(e.ok));
        chk("resp_data",    resp_data, e.data);
        if (e.lat >= 0) chk("resp_latency", 64'(cyc - gtime[e.idx]), 64'(e.lat));
      end
    end
  end

  // Datapath model: each ISSUE pops a scripted attempt; done on the n-th WAIT cycle.
  initial begin
    task_done = 1'b0; task_success = 1'b0; read_data = '0; m_active = 1'b0; m_cnt = 0;
    forever begin
      @(posedge clk); #1;
      task_done = 1'b0; task_success = 1'b0; read_data = '0;
      if (!rst_b) m_active = 1'b0;
      else if (!m_active && tsk != 0) begin
        m_active = 1'b1; m_cnt = 0; iss_cnt++;
        if (atq.size() == 0) begin
          m_cur = '{0, 1'b0, 64'd0, 2'd0, 16'd0, 64'd0};
          n_vec++; n_err++;
          $display("FAIL issue_unexpected: tsk=%b with no attempt scripted", tsk);
        end else begin
          m_cur = atq.pop_front();
          chk("issue_tsk",     64'(tsk), 64'(m_cur.tsk));
          chk("issue_mempage", 64'(mempage), 64'(m_cur.page));
          chk("issue_data_in", data_in, m_cur.wdata);
        end
      end else if (m_active) begin
        if (tsk == 0) m_active = 1'b0;
        else begin
          m_cnt++;
          if (m_cnt == m_cur.delay) begin
            task_done = 1'b1; task_success = m_cur.ok; read_data = m_cur.rdata;
          end
        end
      end
    end
  end

  task automatic send(input int i, input logic [1:0] t, input logic [15:0] pg, input logic [63:0] d);
    int n = 0;
    req_tsk[i] = t; req_mempage[i] = pg; req_data[i] = d; req_valid[i] = 1'b1;
    #1;
    while (!req_ready[i] && n < 400) begin
      @(posedge clk); #2; n++;
    end
    if (!req_ready[i]) begin
      n_vec++; n_err++;
      $display("FAIL grant_timeout: requester %0d never saw req_ready", i);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || atq.size() != 0) && n < 600) begin
      @(posedge clk); n++;
    end
    chk("drain_pending", 64'(sb.size() + atq.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int c0, i0;

  initial begin
    req_valid = '0; req_tsk = '0; req_mempage = '0; req_data = '0;
    repeat (2) @(posedge clk); #1;
    req_valid = 2'b11; #1;
    chk_zero("in_reset");
    req_valid = '0;
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk); #1;
    chk_zero("idle_after_reset");

    // Both requesters pending from reset: grants alternate starting at 0.
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    atq.push_back('{1, 1'b1, 64'hA1A1_0000_0000_0001, 2'b01, 16'h0010, 64'h10});
    atq.push_back('{1, 1'b1, 64'hBADB_AD00_0000_0002, 2'b10, 16'h0020, 64'h20});
    atq.push_back('{1, 1'b1, 64'hA3A3_0000_0000_0003, 2'b01, 16'h0011, 64'h11});
    atq.push_back('{1, 1'b1, 64'hBADB_AD00_0000_0004, 2'b10, 16'h0021, 64'h21});
    sb.push_back('{0, 1'b1, 64'hA1A1_0000_0000_0001, 4});
    sb.push_back('{1, 1'b1, 64'd0, 4});
    sb.push_back('{0, 1'b1, 64'hA3A3_0000_0000_0003, 4});
    sb.push_back('{1, 1'b1, 64'd0, 4});
    fork
      begin send(0, 2'b01, 16'h0010, 64'h10); send(0, 2'b01, 16'h0011, 64'h11); end
      begin send(1, 2'b10, 16'h0020, 64'h20); send(1, 2'b10, 16'h0021, 64'h21); end
    join
    drain();

    // Single read, done on the third WAIT cycle: response 6 cycles after grant.
    c0 = clr_cnt; i0 = iss_cnt;
    gq.push_back(0);
    atq.push_back('{3, 1'b1, 64'h1122334455667788, 2'b01, 16'h00A5, 64'h0});
    sb.push_back('{0, 1'b1, 64'h1122334455667788, 6});
    send(0, 2'b01, 16'h00A5, 64'h0);
    drain();
    chk("read_clr_pulses", 64'(clr_cnt - c0), 64'd1);
    chk("read_issues", 64'(iss_cnt - i0), 64'd1);
    chk("resp_hold_success", 64'(resp_success), 64'd1);
    chk("resp_hold_data", resp_data, 64'h1122334455667788);
    chk("busy_idle", 64'(busy), 64'd0);

    // Write: two failures then success; read_data ignored for writes.
    c0 = clr_cnt; i0 = iss_cnt;
    gq.push_back(1);
    atq.push_back('{2, 1'b0, 64'h5555, 2'b10, 16'h1234, 64'hDEADBEEF});
    atq.push_back('{1, 1'b0, 64'h6666, 2'b10, 16'h1234, 64'hDEADBEEF});
    atq.push_back('{3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 16'h1234, 64'hDEADBEEF});
    sb.push_back('{1, 1'b1, 64'd0, 1 + (2+2) + (1+2) + (3+2)});
    send(1, 2'b10, 16'h1234, 64'hDEADBEEF);
    drain();
    chk("retry_clr_pulses", 64'(clr_cnt - c0), 64'd3);
    chk("retry_issues", 64'(iss_cnt - i0), 64'd3);

    // No task_done at all: three full-timeout attempts, then failure.
    c0 = clr_cnt; i0 = iss_cnt;
    gq.push_back(1);
    for (int k = 0; k < 3; k++) atq.push_back('{0, 1'b0, 64'd0, 2'b01, 16'h0042, 64'h7});
    sb.push_back('{1, 1'b0, 64'd0, 1 + 3 * (TMO + 2)});
    send(1, 2'b01, 16'h0042, 64'h7);
    drain();
    chk("tmo_clr_pulses", 64'(clr_cnt - c0), 64'd3);
    chk("tmo_issues", 64'(iss_cnt - i0), 64'd3);

    // task_done on the timeout cycle wins.
    c0 = clr_cnt;
    gq.push_back(0);
    atq.push_back('{TMO, 1'b1, 64'hCAFE_F00D_0000_0016, 2'b01, 16'h0777, 64'h0});
    sb.push_back('{0, 1'b1, 64'hCAFE_F00D_0000_0016, 3 + TMO});
    send(0, 2'b01, 16'h0777, 64'h0);
    drain();
    chk("edge_clr_pulses", 64'(clr_cnt - c0), 64'd1);

    // Illegal codes: accepted, no datapath activity, failure response.
    c0 = clr_cnt; i0 = iss_cnt;
    gq.push_back(0); sb.push_back('{0, 1'b0, 64'd0, -1});
    send(0, 2'b11, 16'h0101, 64'h99);
    gq.push_back(1); sb.push_back('{1, 1'b0, 64'd0, -1});
    send(1, 2'b00, 16'h0202, 64'h98);
    drain();
    chk("illegal_clr_pulses", 64'(clr_cnt - c0), 64'd0);
    chk("illegal_issues", 64'(iss_cnt - i0), 64'd0);

    // Reset during WAIT: everything drops at once, no response follows.
    gq.push_back(0);
    atq.push_back('{0, 1'b0, 64'd0, 2'b01, 16'h0BAD, 64'h0});
    send(0, 2'b01, 16'h0BAD, 64'h0);
    repeat (4) @(posedge clk);
    #3;
    chk("busy_in_wait", 64'(busy), 64'd1);
    atq.delete();
    rst_b = 1'b0;
    #1;
    chk_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_zero("post_reset_idle");
    gq.push_back(1);
    atq.push_back('{2, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 2'b01, 16'h3333, 64'h0});
    sb.push_back('{1, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 5});
    send(1, 2'b01, 16'h3333, 64'h0);
    drain();
    chk("grants_consumed", 64'(gq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
